seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, meaning the number of multiplexed digits (range 1..8).
REQ-002 The block SHALL have parameter VAL_WIDTH, default 16, meaning the width of the binary input value (range 1..32).
REQ-003 The block SHALL have parameter REFRESH_DIV, default 100000, meaning the clk cycles each digit stays selected (minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port value, input, VAL_WIDTH bits: the binary value to display.
REQ-007 The block SHALL have port load, input, 1 bit: one-cycle capture strobe for value.
REQ-008 The block SHALL have port dec_mode, input, 1 bit: sampled with load; 0 = hex display, 1 = decimal display.
REQ-009 The block SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, applied live.
REQ-010 The block SHALL have port dp_mask, input, NUM_DIGITS bits: bit i=1 lights digit i's decimal point, applied live.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a decimal conversion is in progress.
REQ-012 The block SHALL have port an, output, NUM_DIGITS bits: active-low one-hot digit anode select.
REQ-013 The block SHALL have port sseg, output, 8 bits: active-low segments, bit7 = dp and bits6..0 = g,f,e,d,c,b,a.

Function
REQ-014 A refresh counter SHALL count 0..REFRESH_DIV-1; at terminal count, digit index idx SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-015 an SHALL drive bit idx low and all other bits high, registered, changing on the same edge as idx.
REQ-016 A display register SHALL hold NUM_DIGITS 4-bit digit codes; sseg SHALL be the registered decode of digit idx, aligned with an.
REQ-017 Decode SHALL be 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E (hex, dp off); sseg[7] SHALL be ~dp_mask[idx].
REQ-018 Hex mode: on load with busy=0, digit i SHALL become value[4i+3:4i], zero-padded above VAL_WIDTH, and the display register SHALL update on the next clock edge.
REQ-019 Decimal mode: on load with busy=0, busy SHALL rise on the next edge and a shift-add-3 BCD converter SHALL run for exactly VAL_WIDTH cycles.
REQ-020 At the end of the conversion, the display register SHALL update with the BCD digits and busy SHALL fall on that same edge; BCD digits beyond NUM_DIGITS SHALL be discarded (truncation).
REQ-021 The display register SHALL keep its previous contents throughout a conversion.
REQ-022 load while busy=1 SHALL be ignored, with no queueing.
REQ-023 A load on the same cycle busy falls SHALL be ignored; a new load is accepted only when busy=0 is sampled.
REQ-024 With blank_lz=1, digit i>0 SHALL output segments 7F (dp still per dp_mask) when it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-025 Scanning SHALL continue uninterrupted during load, conversion and mode changes.

Reset
REQ-026 While rst=1, the block SHALL hold an = all ones, sseg = FF, busy = 0, idx = 0, refresh counter = 0, display register = 0, and converter state cleared.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion and leave the display register at 0.
REQ-028 On the first edge after rst falls, an SHALL select digit 0 showing C0 (or 7F/40 per dp_mask where applicable).

Configuration
REQ-029 With macro SEVSEG_BCD_EN defined, the block SHALL include decimal mode as specified.
REQ-030 Without SEVSEG_BCD_EN, the block SHALL omit converter logic, ignore dec_mode (treat as 0), tie busy to 0, and always use the REQ-018 hex path.

Verification (NUM_DIGITS=8, VAL_WIDTH=16, REFRESH_DIV=4)
REQ-031 Reset release with no load -> an steps FE, FD, ... 7F every 4 cycles, then wraps to FE; sseg = C0 on every digit.
REQ-032 Hex load of value=0x1A3F, blank_lz=0 -> next edge digits 3..0 = F9, 88, B0, 8E; digits 7..4 = C0.
REQ-033 Decimal load of value=65535, blank_lz=1 -> busy high for 16 cycles; then digits 4..0 = 6,5,5,3,5 (82, 92, 92, B0, 92) and digits 7..5 = 7F.
REQ-034 Second load of 0x0001 while busy -> ignored; result stays 65535; busy stays high exactly 16 cycles total.
REQ-035 rst pulsed at cycle 8 of a conversion -> busy = 0, display all C0, an restarts at FE.
REQ-036 dp_mask = 0x01 with digit 0 = 0 -> sseg = 40 when an = FE; with the macro undefined and dec_mode=1, a load of 255 shows hex FF (8E, 8E).

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed seven-segment scanner with hex display
// and optional decimal (shift-add-3 BCD) display.
//
// Optional feature macro: SEVSEG_BCD_EN
//   defined   -> decimal mode available (dec_mode sampled with load, busy
//                high for VAL_WIDTH cycles while converting)
//   undefined -> hex only, dec_mode ignored, busy tied low
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   value     binary value to display (VAL_WIDTH bits)
//   load      one-cycle capture strobe for value
//   dec_mode  0 = hex, 1 = decimal (sampled with load)
//   blank_lz  leading-zero blanking enable (live)
//   dp_mask   per-digit decimal point enable (live)
//   busy      decimal conversion in progress
//   an        active-low one-hot digit anode select (registered)
//   sseg      active-low segments {dp,g,f,e,d,c,b,a} (registered)

module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int VAL_WIDTH   = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VAL_WIDTH-1:0]  value,
  input  logic                  load,
  input  logic                  dec_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            sseg
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // 32-bit input needs at most 10 BCD digits
  localparam int BW = 40;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS out of range 1..8");
  end
  if (VAL_WIDTH < 1 || VAL_WIDTH > 32) begin : g_bad_width
    $error("VAL_WIDTH out of range 1..32");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be at least 2");
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------
  // scan state
  // ---------------------------------------------------------------
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;
  logic [DW-1:0]         disp_q, disp_d;

  // converter handshake, driven by either build variant
  logic          busy_o;
  logic          conv_done;
  logic          hex_load;
  logic [DW-1:0] bcd_res;

`ifdef SEVSEG_BCD_EN

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_e;

  localparam logic [5:0] BIT_LAST = 6'(VAL_WIDTH - 1);

  // one shift-add-3 iteration: correct every digit, then shift in bit
  function automatic logic [BW-1:0] bcd_step(
    input logic [BW-1:0] b,
    input logic          in_bit
  );
    logic [BW-1:0] t;
    t = b;
    for (int d = 0; d < BW / 4; d++) begin
      if (t[4*d +: 4] >= 4'd5) begin
        t[4*d +: 4] = t[4*d +: 4] + 4'd3;
      end
    end
    return {t[BW-2:0], in_bit};
  endfunction

  state_e               state_q, state_d;
  logic [VAL_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [5:0]           bit_q, bit_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin : conv_next
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    bit_d   = bit_q;
    unique case (state_q)
      S_IDLE: begin
        if (load && dec_mode) begin
          state_d = S_CONV;
          bin_d   = value;
          bcd_d   = '0;
          bit_d   = '0;
        end
      end
      S_CONV: begin
        bcd_d = bcd_step(bcd_q, bin_q[VAL_WIDTH-1]);
        bin_d = bin_q << 1;
        bit_d = bit_q + 6'd1;
        if (conv_done) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // loads are only looked at in S_IDLE, so a strobe on the cycle busy
  // drops is dropped rather than queued
  always_comb begin : conv_out
    busy_o    = (state_q == S_CONV);
    conv_done = (state_q == S_CONV) && (bit_q == BIT_LAST);
    hex_load  = load && (state_q == S_IDLE) && !dec_mode;
  end

  // digits above NUM_DIGITS are discarded
  assign bcd_res = bcd_d[DW-1:0];

`else

  logic unused_dec_mode;
  assign unused_dec_mode = dec_mode;

  always_comb begin : conv_out
    busy_o    = 1'b0;
    conv_done = 1'b0;
    hex_load  = load;
  end

  assign bcd_res = '0;

`endif

  assign busy = busy_o;

  // ---------------------------------------------------------------
  // display register
  // ---------------------------------------------------------------
  always_comb begin : disp_next
    disp_d = disp_q;
    if (hex_load) begin
      disp_d = DW'(value);
    end
    if (conv_done) begin
      disp_d = bcd_res;
    end
  end

  // ---------------------------------------------------------------
  // refresh counter and digit index
  // ---------------------------------------------------------------
  always_comb begin : scan_next
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    an_d = ~(NUM_DIGITS'(1) << idx_d);
  end

  // ---------------------------------------------------------------
  // leading-zero blanking: a digit blanks when it and every digit
  // above it are zero; digit 0 always shows
  // ---------------------------------------------------------------
  logic [NUM_DIGITS-1:0] blank_vec;

  always_comb begin : lz_scan
    logic lz;
    lz        = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz           = lz & (disp_d[4*i +: 4] == 4'h0);
      blank_vec[i] = lz & (i != 0);
    end
  end

  // ---------------------------------------------------------------
  // segment decode: uses next idx/display so sseg lines up with an
  // ---------------------------------------------------------------
  logic [3:0] cur_dig;

  always_comb begin : seg_next
    cur_dig = disp_d[{idx_d, 2'b00} +: 4];
    sseg_d  = {~dp_mask[idx_d], seg7(cur_dig)};
    if (blank_lz && blank_vec[idx_d]) begin
      sseg_d[6:0] = 7'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      sseg_q <= 8'hFF;
      disp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      disp_q <= disp_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed tests for seven_seg_scan_driver
// (NUM_DIGITS=8, VAL_WIDTH=16, REFRESH_DIV=4).

module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        dec_mode;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic        busy;
  logic [7:0]  an;
  logic [7:0]  sseg;

  int checks   = 0;
  int failures = 0;

  logic [7:0] seen [8];

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS (8),
    .VAL_WIDTH  (16),
    .REFRESH_DIV(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .load    (load),
    .dec_mode(dec_mode),
    .blank_lz(blank_lz),
    .dp_mask (dp_mask),
    .busy    (busy),
    .an      (an),
    .sseg    (sseg)
  );

  // record what each digit shows over a full scan (32 cycles + margin)
  task automatic capture();
    for (int k = 0; k < 8; k++) seen[k] = 8'hxx;
    repeat (34) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        if (an === ~(8'd1 << k)) seen[k] = sseg;
      end
    end
  endtask

  task automatic wait_an(input logic [7:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an === target) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    load     = 1'b0;
    dec_mode = 1'b0;
    blank_lz = 1'b0;
    dp_mask  = 8'h00;
    value    = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 8'hFF) begin
      failures++;
      $display("FAIL reset_an got=%h exp=%h", an, 8'hFF);
    end
    checks++;
    if (sseg !== 8'hFF) begin
      failures++;
      $display("FAIL reset_sseg got=%h exp=%h", sseg, 8'hFF);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 8'hFE) begin
      failures++;
      $display("FAIL release_an got=%h exp=%h", an, 8'hFE);
    end
    checks++;
    if (sseg !== 8'hC0) begin
      failures++;
      $display("FAIL release_sseg got=%h exp=%h", sseg, 8'hC0);
    end
  endtask

  // first digit holds 3 more cycles (counter already at 1), then 4 each
  task automatic test_scan();
    logic [7:0] e;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 8'hFD) begin
      failures++;
      $display("FAIL scan_an1 got=%h exp=%h", an, 8'hFD);
    end
    for (int k = 2; k <= 8; k++) begin
      repeat (4) @(negedge clk);
      e = ~(8'd1 << (k % 8));
      checks++;
      if (an !== e) begin
        failures++;
        $display("FAIL scan_an%0d got=%h exp=%h", k, an, e);
      end
      checks++;
      if (sseg !== 8'hC0) begin
        failures++;
        $display("FAIL scan_sseg%0d got=%h exp=%h", k, sseg, 8'hC0);
      end
    end
  endtask

  task automatic test_hex();
    logic [7:0] hx [8];
    logic [7:0] e;
    hx[0] = 8'h8E;
    hx[1] = 8'hB0;
    hx[2] = 8'h88;
    hx[3] = 8'hF9;
    for (int k = 4; k < 8; k++) hx[k] = 8'hC0;
    value    = 16'h1A3F;
    dec_mode = 1'b0;
    blank_lz = 1'b0;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    e = 8'hxx;
    for (int k = 0; k < 8; k++) begin
      if (an === ~(8'd1 << k)) e = hx[k];
    end
    checks++;
    if (sseg !== e) begin
      failures++;
      $display("FAIL hex_next_edge got=%h exp=%h", sseg, e);
    end
    capture();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (seen[k] !== hx[k]) begin
        failures++;
        $display("FAIL hex_digit%0d got=%h exp=%h", k, seen[k], hx[k]);
      end
    end
  endtask

`ifdef SEVSEG_BCD_EN
  task automatic test_decimal();
    logic [7:0] dx [5];
    logic [7:0] pb [8];
    int n;
    dx[0] = 8'h92;
    dx[1] = 8'hB0;
    dx[2] = 8'h92;
    dx[3] = 8'h92;
    dx[4] = 8'h82;
    // previous 0x1A3F contents with leading zeros blanked
    pb[0] = 8'h8E;
    pb[1] = 8'hB0;
    pb[2] = 8'h88;
    pb[3] = 8'hF9;
    for (int k = 4; k < 8; k++) pb[k] = 8'hFF;
    blank_lz = 1'b1;
    value    = 16'd65535;
    dec_mode = 1'b1;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL dec_busy_rise got=%b exp=1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      load = 1'b0;
      if (n == 4 || n == 15) begin
        value = 16'h0001;
        load  = 1'b1;
      end
      if (n == 8) begin
        for (int k = 0; k < 8; k++) begin
          if (an === ~(8'd1 << k)) begin
            checks++;
            if (sseg[6:0] !== pb[k][6:0]) begin
              failures++;
              $display("FAIL dec_hold_d%0d got=%h exp=%h", k, sseg[6:0], pb[k][6:0]);
            end
          end
        end
      end
      n++;
      @(negedge clk);
    end
    load     = 1'b0;
    dec_mode = 1'b0;
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL dec_busy_len got=%0d exp=16", n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL dec_fall_load got=%b exp=0", busy);
    end
    capture();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (seen[k] !== dx[k]) begin
        failures++;
        $display("FAIL dec_digit%0d got=%h exp=%h", k, seen[k], dx[k]);
      end
    end
    for (int k = 5; k < 8; k++) begin
      checks++;
      if (seen[k][6:0] !== 7'h7F) begin
        failures++;
        $display("FAIL dec_blank%0d got=%h exp=%h", k, seen[k][6:0], 7'h7F);
      end
    end
  endtask
`else
  task automatic test_hex_dec_ignored();
    blank_lz = 1'b0;
    value    = 16'd255;
    dec_mode = 1'b1;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    dec_mode = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL nobcd_busy got=%b exp=0", busy);
    end
    capture();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      e = (k < 2) ? 8'h8E : 8'hC0;
      checks++;
      if (seen[k] !== e) begin
        failures++;
        $display("FAIL nobcd_digit%0d got=%h exp=%h", k, seen[k], e);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    blank_lz = 1'b0;
    value    = 16'hFFFF;
    dec_mode = 1'b1;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_busy got=%b exp=0", busy);
    end
    checks++;
    if (an !== 8'hFF || sseg !== 8'hFF) begin
      failures++;
      $display("FAIL rstmid_out got=%h/%h exp=FF/FF", an, sseg);
    end
    rst      = 1'b0;
    dec_mode = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 8'hFE) begin
      failures++;
      $display("FAIL rstmid_an got=%h exp=%h", an, 8'hFE);
    end
    capture();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_busy_after got=%b exp=0", busy);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (seen[k] !== 8'hC0) begin
        failures++;
        $display("FAIL rstmid_digit%0d got=%h exp=%h", k, seen[k], 8'hC0);
      end
    end
  endtask

  task automatic test_dp();
    bit ok;
    dp_mask  = 8'h01;
    blank_lz = 1'b0;
    @(negedge clk);
    wait_an(8'hFE, ok);
    checks++;
    if (!ok || sseg !== 8'h40) begin
      failures++;
      $display("FAIL dp_digit0 got=%h exp=%h found=%b", sseg, 8'h40, ok);
    end
    wait_an(8'hFD, ok);
    checks++;
    if (!ok || sseg !== 8'hC0) begin
      failures++;
      $display("FAIL dp_digit1 got=%h exp=%h found=%b", sseg, 8'hC0, ok);
    end
    dp_mask  = 8'h02;
    blank_lz = 1'b1;
    @(negedge clk);
    wait_an(8'hFD, ok);
    checks++;
    if (!ok || sseg !== 8'h7F) begin
      failures++;
      $display("FAIL blank_dp_digit1 got=%h exp=%h found=%b", sseg, 8'h7F, ok);
    end
    wait_an(8'hFE, ok);
    checks++;
    if (!ok || sseg !== 8'hC0) begin
      failures++;
      $display("FAIL blank_digit0 got=%h exp=%h found=%b", sseg, 8'hC0, ok);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
`ifdef SEVSEG_BCD_EN
    test_decimal();
`else
    test_hex_dec_ignored();
`endif
    test_reset_mid();
    test_dp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
